// File: rtl/addbit_serial.sv
// Digit-serial adder/subtractor: one DIGIT-wide add cell iterated LSB to MSB,
// start/busy/done handshake. Define ADDBIT_SERIAL_OVF_EN to add the signed-overflow output ovf.
module addbit_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef ADDBIT_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $fatal(1, "addbit_serial: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)", WIDTH, DIGIT);
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, psum, psum_n;
  logic             carry;
  logic [SW-1:0]    step;
  logic [DIGIT-1:0] a_d, b_d, s_d;
  logic             c_d;
  logic             last;

  // b_q already holds ~b for subtraction, so the cell is always a plain adder
  always_comb begin
    a_d           = a_q[step*DIGIT +: DIGIT];
    b_d           = b_q[step*DIGIT +: DIGIT];
    {c_d, s_d}    = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
    psum_n        = psum;
    psum_n[step*DIGIT +: DIGIT] = s_d;
    last          = (step == SW'(STEPS - 1));
  end

`ifdef ADDBIT_SERIAL_OVF_EN
  // carry into the MSB recovered from the MSB's own sum bit
  logic c_msb;
  assign c_msb = a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ s_d[DIGIT-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      psum  <= '0;
      carry <= 1'b0;
      step  <= '0;
`ifdef ADDBIT_SERIAL_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub | ci;
            step  <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          psum  <= psum_n;
          carry <= c_d;
          step  <= step + 1'b1;
          if (last) begin
            sum   <= psum_n;
            co    <= c_d;
`ifdef ADDBIT_SERIAL_OVF_EN
            ovf   <= c_msb ^ c_d;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addbit_serial.sv
// Bench for addbit_serial: directed 8-bit cases plus a 16-bit random sweep over
// DIGIT 1/4/16, checked through per-instance scoreboards.
module tb_addbit_serial;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic [31:0] t;
  } sb_t;

  logic              clk, rst, sub, ci;
  logic [15:0]       a, b;
  logic [3:0]        start, busy, done, cov;
  logic [3:0][15:0]  sumv;
`ifdef ADDBIT_SERIAL_OVF_EN
  logic [3:0]        ovv;
`endif
  int                nchk = 0;
  int                nfail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic sb_t ref_add(input int w, input logic [15:0] av, input logic [15:0] bv,
                                  input logic cv, input logic sv);
    logic [15:0] m, aa, bb;
    logic [16:0] r;
    sb_t         o;
    m    = 16'hFFFF >> (16 - w);
    aa   = av & m;
    bb   = (sv ? ~bv : bv) & m;
    r    = {1'b0, aa} + {1'b0, bb} + 17'(sv | cv);
    o.s  = r[15:0] & m;
    o.co = r[w];
    o.ov = (aa[w-1] == bb[w-1]) && (o.s[w-1] != aa[w-1]);
    o.t  = 0;
    return o;
  endfunction

  // instance 0: WIDTH=8 DIGIT=1; instances 1..3: WIDTH=16 DIGIT=1/4/16
  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int W  = (k == 0) ? 8 : 16;
    localparam int D  = (k == 2) ? 4 : (k == 3) ? 16 : 1;
    localparam int ST = W / D;
    logic [W-1:0] s_w;
    logic         co_w;
`ifdef ADDBIT_SERIAL_OVF_EN
    logic         ov_w;
    assign ovv[k] = ov_w;
`endif
    addbit_serial #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start[k]),
      .sub   (sub),
      .a     (a[W-1:0]),
      .b     (b[W-1:0]),
      .ci    (ci),
      .busy  (busy[k]),
      .done  (done[k]),
      .sum   (s_w),
      .co    (co_w)
`ifdef ADDBIT_SERIAL_OVF_EN
      ,
      .ovf   (ov_w)
`endif
    );
    assign sumv[k] = 16'(s_w);
    assign cov[k]  = co_w;

    int unsigned cyc = 0;
    sb_t         q[$];
    sb_t         e;
    logic [15:0] last_s = '0;
    logic        last_co = 1'b0;

    // push on the accepting edge, check on the following falling edge
    always begin
      @(posedge clk);
      cyc++;
      if (!rst && start[k] && !busy[k]) begin
        e   = ref_add(W, a, b, ci, sub);
        e.t = cyc;
        q.push_back(e);
      end
      @(negedge clk);
      if (rst) begin
        q.delete();
        last_s  = '0;
        last_co = 1'b0;
      end else begin
        if (busy[k]) begin
          chk($sformatf("hold_sum%0d", k), sumv[k], last_s);
          chk($sformatf("hold_co%0d", k), cov[k], last_co);
          chk($sformatf("done_in_busy%0d", k), done[k], 0);
        end
        if (done[k]) begin
          if (q.size() == 0) chk($sformatf("unexpected_done%0d", k), 1, 0);
          else begin
            e = q.pop_front();
            chk($sformatf("sum%0d", k), sumv[k], e.s);
            chk($sformatf("co%0d", k), cov[k], e.co);
            chk($sformatf("latency%0d", k), cyc - e.t, ST);
`ifdef ADDBIT_SERIAL_OVF_EN
            chk($sformatf("ovf%0d", k), ovv[k], e.ov);
`endif
            last_s  = e.s;
            last_co = e.co;
          end
        end
      end
    end
  end

  task automatic op(input logic [3:0] m, input logic [15:0] av, input logic [15:0] bv,
                    input logic cv, input logic sv);
    int n;
    @(negedge clk);
    a = av; b = bv; ci = cv; sub = sv; start = m;
    @(negedge clk);
    start = '0;
    n = 0;
    while ((busy & m) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("op_timeout", 1, 0);
  endtask

  task automatic wait_done0();
    int n;
    n = 0;
    while (!done[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done0", done[0], 1);
  endtask

  task automatic dir8(input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input logic cv, input logic sv, input logic [7:0] es, input logic ec,
                      input logic eo);
    op(4'b0001, av, bv, cv, sv);
    chk({tag, "_done"}, done[0], 1);
    chk({tag, "_sum"}, sumv[0], {8'h00, es});
    chk({tag, "_co"}, cov[0], ec);
`ifdef ADDBIT_SERIAL_OVF_EN
    chk({tag, "_ovf"}, ovv[0], eo);
`else
    if (eo && !eo) chk({tag, "_ovf"}, 0, 1);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=expired exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = '0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_busy%0d", k), busy[k], 0);
      chk($sformatf("rst_done%0d", k), done[k], 0);
      chk($sformatf("rst_sum%0d", k), sumv[k], 0);
      chk($sformatf("rst_co%0d", k), cov[k], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    dir8("add5a3c", 16'h005A, 16'h003C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    dir8("addff01", 16'h00FF, 16'h0001, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    dir8("sub1020", 16'h0010, 16'h0020, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    dir8("sub2010", 16'h0020, 16'h0010, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0);

    // back-to-back accept in the done cycle; a start during busy is dropped
    @(negedge clk);
    a = 16'd1; b = 16'd2; ci = 1'b0; sub = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done0();
    chk("b2b_first", sumv[0], 16'd3);
    a = 16'd3; b = 16'd4; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("b2b_busy", busy[0], 1);
    chk("b2b_hold", sumv[0], 16'd3);
    a = 16'h00FF; b = 16'h00FF; ci = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done0();
    chk("b2b_second", sumv[0], 16'd7);
    chk("b2b_co", cov[0], 0);
    repeat (12) @(negedge clk);
    chk("b2b_no_queue", busy[0], 0);

    // reset asserted between edges after three digits
    @(negedge clk);
    a = 16'h0010; b = 16'h0005; ci = 1'b0; sub = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_done", done[0], 0);
    chk("mid_rst_sum", sumv[0], 0);
    chk("mid_rst_co", cov[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_done", done[0], 0);
    dir8("post_rst", 16'h0021, 16'h0012, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++)
      op(4'hF, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    repeat (4) @(negedge clk);
    chk("drain0", g_dut[0].q.size(), 0);
    chk("drain1", g_dut[1].q.size(), 0);
    chk("drain2", g_dut[2].q.size(), 0);
    chk("drain3", g_dut[3].q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/addbit_serial.md
Name: addbit_serial

Overview:
- Parametrised successor to the 1-bit gate/RTL full adder.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, by iterating one DIGIT-wide add cell from LSB to MSB.
- Sits in test/demo hierarchies as a multi-cycle arithmetic unit with a start/done handshake, so PLI signal-dump tasks can observe internal state mid-operation.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥1.
- DIGIT, 1, bits processed per cycle; WIDTH must be an integer multiple of DIGIT (elaboration-time check, $fatal otherwise).
- STEPS, derived = WIDTH/DIGIT, cycles per operation; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ci  input  1  carry-in for add; ignored when sub=1.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse, result valid.
- sum  output  WIDTH  registered result.
- co  output  1  carry-out of MSB; for sub, 1 = no borrow.

Interface (already decided):
- One clock: clk.
- Reset is asynchronous and active-high: rst.

Behaviour:
- Reset (async, immediate on rst=1) clears outputs and internal state:
  - busy=0, done=0, sum=0, co=0.
  - FSM=IDLE; step counter=0; operand and partial-sum registers=0; carry=0.
- FSM states:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1.
- Accept: at a rising edge with busy=0 and start=1 (state IDLE or DONE):
  - Latch a, b, sub.
  - Latch b_eff = sub ? ~b : b.
  - Latch carry = sub ? 1 : ci.
  - Clear step=0; go to RUN.
- RUN: each edge processes one digit, index i = step:
  - {c, s} = a[i*DIGIT +: DIGIT] + b_eff[same] + carry, computed DIGIT+1 bits wide.
  - Write s into partial-sum slice i; carry ← c; step++.
  - On the edge where step==STEPS-1: sum ← full partial-sum incl. this slice, co ← c, go to DONE.
  - busy is high for exactly STEPS cycles.
- DONE: done=1 for one cycle.
  - Next edge: start=1 → accept (back-to-back, no idle gap); else → IDLE.
- Holding and ignored inputs:
  - sum/co hold their value until the next completion; they never change during RUN.
  - start while busy=1 is ignored, not queued.
  - a, b, ci, sub may change freely while busy=1 without affecting the result.
- Arithmetic: modulo 2^WIDTH; co is the true carry out of bit WIDTH-1.
- Reset mid-RUN: abort immediately, outputs return to reset values, no done pulse.
- DIGIT==WIDTH: STEPS=1, result one cycle after accept.

Optional Feature:
- Macro: ADDBIT_SERIAL_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit, reset 0).
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (two's-complement signed overflow).
  - Updated on the same edge as sum/co and held likewise.
  - Requires tracking the carry into the MSB of the final digit.
- Not defined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, DIGIT=1, a=0x5A, b=0x3C, ci=0, sub=0, start pulsed → busy for 8 cycles; then done=1 one cycle, sum=0x96, co=0 (ovf=1 if macro defined).
- WIDTH=8, DIGIT=2, a=0xFF, b=0x01, ci=1, add → after 4 busy cycles: sum=0x01, co=1, ovf=0.
- WIDTH=8, DIGIT=4, sub=1, a=0x10, b=0x20 → after 2 cycles: sum=0xF0, co=0 (borrow); repeat with a=0x20, b=0x10 → sum=0x10, co=1.
- Back-to-back: start held high with new operands during the DONE cycle → next op accepted on that edge; busy rises the next cycle; first result holds until second completes. Start pulses during busy are ignored.
- Reset mid-op: assert rst asynchronously (between edges) at step 3 of 8 → busy, done, sum, co go to 0 immediately; no done afterwards; a fresh start after rst release completes correctly.
- Sweep: WIDTH=16, DIGIT∈{1,4,16}, 1000 random a/b/ci/sub → sum/co match a reference model every time; done pulses exactly STEPS cycles after each accept.
